regfile_read_sequencer: RTL and testbench

Sequences a single shared register-file read port, the 32-bit 32x1 operand mux, across the multiple register reads one SPARC V8 instruction needs: rs1, rs2, and store data rd / rd+1 for STD. It owns the mux `sel` input, captures each read into a dedicated operand register, and signals completion to the execute-stage control. It sits between decode and the register-file read mux, so one read port serves instructions that need up to four operands.

---
 rtl/regfile_read_sequencer.sv | 142 ++++++++++++++
 tb/tb_regfile_read_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_read_sequencer.sv
// Steps one shared register-file read port through rs1, rs2 and store-data reads for one
// instruction. Optional build macro: REG_G0_SKIP_EN (skip %g0 reads, operand loads 0).
module regfile_read_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic             use_rs2,
    input  logic             use_rd,
    input  logic             dbl,
    input  logic [WIDTH-1:0] rdata,
    output logic [AW-1:0]    sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] opc,
    output logic [WIDTH-1:0] opd
);

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StRdC, StRdD, StDone} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   rs1_q, rs2_q, rd_q;
    logic            use_rs2_q, use_rd_q, dbl_q;

    logic [AW-1:0]   src_rs1, src_rs2, idx_c, idx_d, sel_d;
    logic            src_use_rs2, src_use_rd, src_dbl;
    logic            need_a, need_b, need_c, need_d;

    function automatic state_e pick(input logic b, input logic c, input logic d);
        if (b)      return StRdB;
        else if (c) return StRdC;
        else if (d) return StRdD;
        else        return StDone;
    endfunction

    // In IDLE the decisions come straight from the inputs so the first sel can be
    // registered on the accepting edge; afterwards they come from the latched copy.
    always_comb begin
        if (state_q == StIdle) begin
            src_rs1     = rs1;
            src_rs2     = rs2;
            idx_c       = dbl ? {rd[AW-1:1], 1'b0} : rd;
            idx_d       = {rd[AW-1:1], 1'b1};
            src_use_rs2 = use_rs2;
            src_use_rd  = use_rd;
            src_dbl     = dbl;
        end else begin
            src_rs1     = rs1_q;
            src_rs2     = rs2_q;
            idx_c       = dbl_q ? {rd_q[AW-1:1], 1'b0} : rd_q;
            idx_d       = {rd_q[AW-1:1], 1'b1};
            src_use_rs2 = use_rs2_q;
            src_use_rd  = use_rd_q;
            src_dbl     = dbl_q;
        end
`ifdef REG_G0_SKIP_EN
        need_a = (src_rs1 != '0);
        need_b = src_use_rs2 && (src_rs2 != '0);
        need_c = src_use_rd && (idx_c != '0);
        need_d = src_use_rd && src_dbl && (idx_d != '0);
`else
        need_a = 1'b1;
        need_b = src_use_rs2;
        need_c = src_use_rd;
        need_d = src_use_rd && src_dbl;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = need_a ? StRdA : pick(need_b, need_c, need_d);
            StRdA:   state_d = pick(need_b, need_c, need_d);
            StRdB:   state_d = pick(1'b0, need_c, need_d);
            StRdC:   state_d = pick(1'b0, 1'b0, need_d);
            StRdD:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        case (state_d)
            StRdA:   sel_d = src_rs1;
            StRdB:   sel_d = src_rs2;
            StRdC:   sel_d = idx_c;
            StRdD:   sel_d = idx_d;
            default: sel_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            use_rs2_q <= 1'b0;
            use_rd_q  <= 1'b0;
            dbl_q     <= 1'b0;
            sel       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            opc       <= '0;
            opd       <= '0;
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            busy    <= (state_d != StIdle);
            done    <= (state_d == StDone);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        rs1_q     <= rs1;
                        rs2_q     <= rs2;
                        rd_q      <= rd;
                        use_rs2_q <= use_rs2;
                        use_rd_q  <= use_rd;
                        dbl_q     <= dbl;
                        opa       <= '0;
                        opb       <= '0;
                        opc       <= '0;
                        opd       <= '0;
                    end
                end
                StRdA:   opa <= rdata;
                StRdB:   opb <= rdata;
                StRdC:   opc <= rdata;
                StRdD:   opd <= rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Table-driven bench for regfile_read_sequencer; the register file is modelled as
// data(i) = i * 0x1111_1111 driven combinationally from sel.
module tb_regfile_read_sequencer;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [4:0]  rs1, rs2, rd;
    logic        use_rs2, use_rd, dbl;
    logic [31:0] rdata;
    logic [4:0]  sel;
    logic        busy, done;
    logic [31:0] opa, opb, opc, opd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rdata = 32'h1111_1111 * {27'd0, sel};

    regfile_read_sequencer dut (
        .clk(clk), .clr_n(clr_n), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd),
        .use_rs2(use_rs2), .use_rd(use_rd), .dbl(dbl), .rdata(rdata), .sel(sel),
        .busy(busy), .done(done), .opa(opa), .opb(opb), .opc(opc), .opd(opd)
    );

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic        u2, ud, db;
        logic [2:0]  n;
        logic [19:0] sels;  // read k uses sels[5k +: 5]
        logic [31:0] a, b, c, d;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] r1, r2, r3, input logic u2, ud, db,
                                input logic [2:0] n, input logic [4:0] s0, s1, s2, s3,
                                input logic [31:0] a, b, c, d);
        vec_t v;
        v.rs1 = r1; v.rs2 = r2; v.rd = r3; v.u2 = u2; v.ud = ud; v.db = db; v.n = n;
        v.sels = {s3, s2, s1, s0};
        v.a = a; v.b = b; v.c = c; v.d = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept at E0, then check every cycle through DONE and the return to IDLE.
    task automatic run_vec(input vec_t v, input bit restart);
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
        use_rs2 = v.u2; use_rd = v.ud; dbl = v.db;
        start = 1'b1;
        step();
        start = restart;
        rs1 = ~v.rs1; rs2 = ~v.rs2; rd = ~v.rd;
        use_rs2 = ~v.u2; use_rd = ~v.ud; dbl = ~v.db;
        for (int k = 0; k < int'(v.n); k++) begin
            chk($sformatf("sel read %0d", k), {27'd0, sel}, {27'd0, v.sels[5*k +: 5]});
            chk($sformatf("busy read %0d", k), {31'd0, busy}, 32'd1);
            chk($sformatf("done early %0d", k), {31'd0, done}, 32'd0);
            if (k >= 2) start = 1'b0;
            step();
        end
        start = 1'b0;
        chk("done pulse", {31'd0, done}, 32'd1);
        chk("busy in done", {31'd0, busy}, 32'd1);
        chk("sel in done", {27'd0, sel}, 32'd0);
        chk("opa", opa, v.a);
        chk("opb", opb, v.b);
        chk("opc", opc, v.c);
        chk("opd", opd, v.d);
        step();
        chk("done cleared", {31'd0, done}, 32'd0);
        chk("busy cleared", {31'd0, busy}, 32'd0);
        chk("opa held", opa, v.a);
        chk("opd held", opd, v.d);
    endtask

    vec_t tbl[7];
    vec_t v2;

    initial begin
        tbl[0] = mk(5, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 32'h5555_5555, 0, 0, 0);
        tbl[1] = mk(3, 7, 0, 1, 0, 0, 2, 3, 7, 0, 0, 32'h3333_3333, 32'h7777_7777, 0, 0);
        tbl[2] = mk(1, 2, 9, 1, 1, 1, 4, 1, 2, 8, 9,
                    32'h1111_1111, 32'h2222_2222, 32'h8888_8888, 32'h9999_9999);
        tbl[3] = mk(10, 0, 12, 0, 1, 0, 2, 10, 12, 0, 0, 32'hAAAA_AAAA, 0, 32'hCCCC_CCCC, 0);
        tbl[4] = mk(2, 0, 7, 0, 0, 1, 1, 2, 0, 0, 0, 32'h2222_2222, 0, 0, 0);
        tbl[5] = mk(6, 0, 4, 0, 1, 1, 3, 6, 4, 5, 0, 32'h6666_6666, 0, 32'h4444_4444,
                    32'h5555_5555);
`ifdef REG_G0_SKIP_EN
        tbl[6] = mk(0, 15, 0, 1, 0, 0, 1, 15, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
`else
        tbl[6] = mk(0, 15, 0, 1, 0, 0, 2, 0, 15, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
`endif

        clr_n = 1'b0; start = 1'b0; rs1 = 0; rs2 = 0; rd = 0;
        use_rs2 = 0; use_rd = 0; dbl = 0;
        #3;
        chk("reset sel", {27'd0, sel}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset opa", opa, 32'd0);
        step();
        step();
        clr_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0);

        // start held high through the first busy cycles must not restart or stretch it
        run_vec(tbl[2], 1'b1);
        chk("no queued start", {31'd0, busy}, 32'd0);

        // async reset in RD_B discards the partial operand
        rs1 = 3; rs2 = 7; use_rs2 = 1; use_rd = 0; dbl = 0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("rdb sel before reset", {27'd0, sel}, 32'd7);
        chk("opa captured before reset", opa, 32'h3333_3333);
        clr_n = 1'b0;
        #1;
        chk("mid reset sel", {27'd0, sel}, 32'd0);
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset opa", opa, 32'd0);
        #1;
        clr_n = 1'b1;
        step();
        chk("idle after reset", {31'd0, busy}, 32'd0);
        run_vec(tbl[0], 1'b0);

`ifdef REG_G0_SKIP_EN
        v2 = mk(0, 4, 0, 1, 0, 0, 1, 4, 0, 0, 0, 0, 32'h4444_4444, 0, 0);
        run_vec(v2, 1'b0);
        v2 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_vec(v2, 1'b0);
`else
        v2 = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_vec(v2, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
